// File: rtl/bitty_pkg.sv
// bitty_pkg: shared types and encodings for the bitty execution unit.
// Opcode and FSM state enums, compare_result encodings, and the helper
// that packs a greater/less pair into a compare code.
package bitty_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_XOR = 3'b010,
    OP_AND = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_LDI = 3'b110,
    OP_CMP = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  // Immediate field width and execute-counter width (EXEC_CYCLES <= 15).
  localparam int unsigned IMM_W = 7;
  localparam int unsigned CNT_W = 4;

  // Greater wins over less; neither means equal.
  function automatic logic [1:0] cmp_encode(input logic gt, input logic lt);
    logic [1:0] code;
    if (gt) begin
      code = CMP_GT;
    end else if (lt) begin
      code = CMP_LT;
    end else begin
      code = CMP_EQ;
    end
    return code;
  endfunction

endpackage

// File: rtl/bitty_alu.sv
// bitty_alu: purely combinational opcode datapath for bitty_exec_unit.
// a is the rd operand, b the rs operand. carry is meaningful for ADD
// (carry-out) and SUB (unsigned borrow) only; cmp is always computed and
// the caller decides which opcode commits it.
// Build option: BITTY_SIGNED_CMP_EN selects a two's-complement compare;
// without it the compare is unsigned.
module bitty_alu
  import bitty_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  opcode_e           opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] value,
  output logic              carry,
  output logic [1:0]        cmp
);

  logic gt_s;
  logic lt_s;

`ifdef BITTY_SIGNED_CMP_EN
  assign gt_s = ($signed(a) > $signed(b));
  assign lt_s = ($signed(a) < $signed(b));
`else
  assign gt_s = (a > b);
  assign lt_s = (a < b);
`endif

  assign cmp = cmp_encode(gt_s, lt_s);

  // Opcode decode: produce the truncated result and the ADD/SUB carry flag.
  always_comb begin
    value = '0;
    carry = 1'b0;
    case (opcode)
      OP_ADD: begin
        {carry, value} = {1'b0, a} + {1'b0, b};
      end
      OP_SUB: begin
        value = a - b;
        carry = (a < b);
      end
      OP_XOR: begin
        value = a ^ b;
      end
      OP_AND: begin
        value = a & b;
      end
      OP_SHL: begin
        value = {a[DATA_W-2:0], 1'b0};
      end
      OP_SHR: begin
        value = {1'b0, a[DATA_W-1:1]};
      end
      OP_LDI: begin
        value = {{(DATA_W-IMM_W){1'b0}}, imm};
      end
      OP_CMP: begin
        value = a;
      end
      default: begin
        value = '0;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/bitty_exec_unit.sv
// bitty_exec_unit: multi-cycle single-issue execution unit with a small
// register file. An instruction is accepted in IDLE, operands are latched
// at acceptance, the unit waits EXEC_CYCLES clocks, then commits result,
// flags and writeback together with a one-cycle done pulse.
// Build option: BITTY_SIGNED_CMP_EN (signed CMP, handled in bitty_alu).
module bitty_exec_unit
  import bitty_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 4,
  parameter int EXEC_CYCLES = 4,
  localparam int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instruction,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic [1:0]        compare_result,
  output logic              carry,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  opcode_e           op_q;
  logic [IDX_W-1:0]  rd_q;
  logic [IMM_W-1:0]  imm_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] result_q;
  logic              done_q;
  logic              carry_q;
  logic [1:0]        cmp_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  opcode_e           op_d;
  logic [IDX_W-1:0]  rd_idx_d;
  logic [IDX_W-1:0]  rs_idx_d;
  logic [DATA_W-1:0] alu_value_d;
  logic              alu_carry_d;
  logic [1:0]        alu_cmp_d;
  logic              instr_unused;

  // Field decode of the offered instruction; only the low index bits matter.
  assign op_d         = opcode_e'(instruction[2:0]);
  assign rd_idx_d     = instruction[3 +: IDX_W];
  assign rs_idx_d     = instruction[6 +: IDX_W];
  assign instr_unused = ^instruction;

  bitty_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .opcode (op_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .value  (alu_value_d),
    .carry  (alu_carry_d),
    .cmp    (alu_cmp_d)
  );

  // Control FSM, operand latch, commit of result/flags and register writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      cmp_q    <= CMP_EQ;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (instr_valid) begin
            op_q    <= op_d;
            rd_q    <= rd_idx_d;
            imm_q   <= instruction[15:9];
            a_q     <= regs_q[rd_idx_d];
            b_q     <= regs_q[rs_idx_d];
            cnt_q   <= CNT_LOAD;
            state_q <= ST_EXEC;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Commit point: everything becomes visible together.
            result_q <= alu_value_d;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
            if (op_q != OP_CMP) begin
              regs_q[rd_q] <= alu_value_d;
            end
            if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
              carry_q <= alu_carry_d;
            end
            if (op_q == OP_CMP) begin
              cmp_q <= alu_cmp_d;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready    = (state_q == ST_IDLE);
  assign result         = result_q;
  assign done           = done_q;
  assign carry          = carry_q;
  assign compare_result = cmp_q;
  assign dbg_data       = regs_q[dbg_addr];

endmodule
